otfs_modulator: RTL and testbench

OTFS_MODULATOR -- requirements
Module: otfs_modulator

---
 rtl/otfs_modulator_if.sv | 41 ++++
 rtl/otfs_modulator.sv | 147 ++++++++++++++
 tb/tb_otfs_modulator.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/otfs_modulator_if.sv
// Bundle between the OTFS modulator, its QAM source, the IFFT core and the TX sample sink.
// master = surrounding system side, slave = otfs_modulator.
interface otfs_modulator_if;
  logic        Start;
  logic        QAMDataValid;
  logic [15:0] QAMDataRe;
  logic [15:0] QAMDataIm;
  logic        IfftCfgValid;
  logic [7:0]  IfftCfgData;
  logic        IfftCfgReady;
  logic        IfftDataValid;
  logic [31:0] IfftData;
  logic        IfftDataLast;
  logic        IfftDataReady;
  logic        IfftOutValid;
  logic [47:0] IfftOutData;
  logic        IfftOutLast;
  logic        OTFSTxValid;
  logic [23:0] OTFSTxRe;
  logic [23:0] OTFSTxIm;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, QAMDataValid, QAMDataRe, QAMDataIm,
    output IfftCfgReady, IfftDataReady,
    output IfftOutValid, IfftOutData, IfftOutLast,
    input  IfftCfgValid, IfftCfgData,
    input  IfftDataValid, IfftData, IfftDataLast,
    input  OTFSTxValid, OTFSTxRe, OTFSTxIm, Busy, Done
  );

  modport slave (
    input  Start, QAMDataValid, QAMDataRe, QAMDataIm,
    input  IfftCfgReady, IfftDataReady,
    input  IfftOutValid, IfftOutData, IfftOutLast,
    output IfftCfgValid, IfftCfgData,
    output IfftDataValid, IfftData, IfftDataLast,
    output OTFSTxValid, OTFSTxRe, OTFSTxIm, Busy, Done
  );
endinterface

// File: rtl/otfs_modulator.sv
// OTFS transmit front end: buffers a 64x64 delay-Doppler frame, feeds it transposed to an IFFT, forwards results.
// Optional macro OTFS_TX_NORM_EN: round-half-up divide of IFFT output by 64 on the TX path.
module otfs_modulator (
  input logic             Clk,
  input logic             Srst,
  otfs_modulator_if.slave bus
);
  localparam int unsigned NDim      = 64;
  localparam int unsigned FrameLen  = NDim * NDim;
  localparam int unsigned AddrW     = 12;
  localparam int unsigned BeatW     = 13;
  localparam int unsigned CntW      = 7;
  localparam int unsigned SymW      = 32;
  localparam int unsigned TxW       = 24;
  localparam logic [7:0]  CfgWord   = 8'b0011_0000;

  typedef enum logic [2:0] {IDLE, CONFIG, LOAD, FEED, DRAIN} state_t;

  state_t           state;
  logic [SymW-1:0]  sym_ram [FrameLen];
  logic [AddrW-1:0] wr_addr;
  logic [BeatW-1:0] rd_beat;
  logic [BeatW-1:0] acc_beat;
  logic [CntW-1:0]  last_cnt;

  logic             ram_we_c;
  logic             rd_en_c;
  logic             accept_c;
  logic             out_act_c;
  logic [AddrW-1:0] rd_addr_c;

  function automatic logic [TxW-1:0] tx_scale(input logic [TxW-1:0] x);
`ifdef OTFS_TX_NORM_EN
    logic signed [TxW:0] s;
    s = $signed({x[TxW-1], x}) + (TxW+1)'(32);
    s = s >>> 6;
    return s[TxW-1:0];
`else
    return x;
`endif
  endfunction

  // Fetch the next beat whenever the output register is empty or being drained this cycle.
  assign ram_we_c  = (state == LOAD) && bus.QAMDataValid;
  assign rd_en_c   = (state == FEED) && !rd_beat[BeatW-1] && (!bus.IfftDataValid || bus.IfftDataReady);
  assign accept_c  = bus.IfftDataValid && bus.IfftDataReady;
  assign out_act_c = (state == FEED) || (state == DRAIN);
  assign rd_addr_c = {rd_beat[5:0], rd_beat[11:6]};

  // Frame buffer, deliberately not reset; every frame rewrites all entries.
  always_ff @(posedge Clk) begin
    if (ram_we_c) begin
      sym_ram[wr_addr] <= {bus.QAMDataIm, bus.QAMDataRe};
    end
  end

  always_ff @(posedge Clk) begin
    if (Srst) begin
      state             <= IDLE;
      wr_addr           <= '0;
      rd_beat           <= '0;
      acc_beat          <= '0;
      last_cnt          <= '0;
      bus.IfftCfgValid  <= 1'b0;
      bus.IfftCfgData   <= '0;
      bus.IfftDataValid <= 1'b0;
      bus.IfftData      <= '0;
      bus.IfftDataLast  <= 1'b0;
      bus.OTFSTxValid   <= 1'b0;
      bus.OTFSTxRe      <= '0;
      bus.OTFSTxIm      <= '0;
      bus.Busy          <= 1'b0;
      bus.Done          <= 1'b0;
    end else begin
      bus.Done <= 1'b0;

      if (out_act_c && bus.IfftOutValid) begin
        bus.OTFSTxValid <= 1'b1;
        bus.OTFSTxRe    <= tx_scale(bus.IfftOutData[23:0]);
        bus.OTFSTxIm    <= tx_scale(bus.IfftOutData[47:24]);
      end else begin
        bus.OTFSTxValid <= 1'b0;
      end

      if ((state != IDLE) && bus.IfftOutValid && bus.IfftOutLast && (last_cnt != CntW'(NDim))) begin
        last_cnt <= last_cnt + CntW'(1);
      end

      // The RAM read register doubles as the IFFT data register, so it holds during stalls.
      if (rd_en_c) begin
        bus.IfftData      <= sym_ram[rd_addr_c];
        bus.IfftDataLast  <= (rd_beat[5:0] == 6'd63);
        bus.IfftDataValid <= 1'b1;
        rd_beat           <= rd_beat + BeatW'(1);
      end else if (bus.IfftDataReady) begin
        bus.IfftDataValid <= 1'b0;
      end

      if (accept_c) begin
        acc_beat <= acc_beat + BeatW'(1);
      end

      case (state)
        IDLE: begin
          if (bus.Start) begin
            state            <= CONFIG;
            bus.IfftCfgValid <= 1'b1;
            bus.IfftCfgData  <= CfgWord;
            bus.Busy         <= 1'b1;
            wr_addr          <= '0;
            rd_beat          <= '0;
            acc_beat         <= '0;
            last_cnt         <= '0;
          end
        end
        CONFIG: begin
          if (bus.IfftCfgReady) begin
            bus.IfftCfgValid <= 1'b0;
            bus.IfftCfgData  <= '0;
            state            <= LOAD;
          end
        end
        LOAD: begin
          if (ram_we_c) begin
            wr_addr <= wr_addr + AddrW'(1);
            if (wr_addr == AddrW'(FrameLen - 1)) begin
              state <= FEED;
            end
          end
        end
        FEED: begin
          if (accept_c && (acc_beat == BeatW'(FrameLen - 1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_cnt == CntW'(NDim)) begin
            state    <= IDLE;
            bus.Done <= 1'b1;
            bus.Busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_otfs_modulator.sv
// Directed bench for otfs_modulator: config handshake, transposed feed, backpressure, drain/done, resets.
module tb_otfs_modulator;
  logic Clk = 1'b0;
  logic Srst;
  int   total = 0;
  int   bad   = 0;

  otfs_modulator_if bus();

  otfs_modulator dut (
    .Clk  (Clk),
    .Srst (Srst),
    .bus  (bus.slave)
  );

  always #5 Clk = ~Clk;

`ifdef OTFS_TX_NORM_EN
  localparam logic [23:0] ExpTxRe = 24'h000001;
  localparam logic [23:0] ExpTxIm = 24'hFFFFFF;
`else
  localparam logic [23:0] ExpTxRe = 24'h000040;
  localparam logic [23:0] ExpTxIm = 24'hFFFFC0;
`endif

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Symbol n of a test frame, packed {Im,Re}
  function automatic logic [31:0] sym(input int kind, input int n);
    logic [15:0] re;
    logic [15:0] im;
    case (kind)
      0: begin re = 16'(n); im = 16'(-n); end
      1: begin re = 16'(n) ^ 16'h5A5A; im = ~16'(n); end
      default: begin re = 16'h1000 + 16'(n); im = 16'(n); end
    endcase
    return {im, re};
  endfunction

  task automatic start_cfg(input int hold);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("cfg_valid_held", 64'(bus.IfftCfgValid), 64'(1));
      chk("cfg_data_held", 64'(bus.IfftCfgData), 64'(8'h30));
      step();
    end
    chk("cfg_valid_pre_ready", 64'(bus.IfftCfgValid), 64'(1));
    chk("busy_in_config", 64'(bus.Busy), 64'(1));
    bus.IfftCfgReady = 1'b1;
    step();
    bus.IfftCfgReady = 1'b0;
    chk("cfg_valid_dropped", 64'(bus.IfftCfgValid), 64'(0));
  endtask

  task automatic load_frame(input int kind, input bit spur_start, input bit spur_out);
    for (int n = 0; n < 4096; n++) begin
      if (n % 611 == 7) begin
        bus.QAMDataValid = 1'b0;
        bus.QAMDataRe    = 16'hBEEF;
        bus.QAMDataIm    = 16'hBEEF;
        step();
      end
      bus.QAMDataValid = 1'b1;
      {bus.QAMDataIm, bus.QAMDataRe} = sym(kind, n);
      bus.Start        = spur_start && (n == 100 || n == 4095);
      bus.IfftOutValid = spur_out && (n < 6);
      bus.IfftOutData  = {24'h000001, 24'h000040};
      bus.IfftOutLast  = 1'b0;
      step();
      if (spur_out && (n < 6)) chk("tx_valid_in_load", 64'(bus.OTFSTxValid), 64'(0));
    end
    bus.QAMDataValid = 1'b0;
    bus.Start        = 1'b0;
    bus.IfftOutValid = 1'b0;
    chk("cfg_valid_after_load", 64'(bus.IfftCfgValid), 64'(0));
    chk("busy_after_load", 64'(bus.Busy), 64'(1));
  endtask

  task automatic feed_frame(input int kind, input bit rnd, input int stop_at, input bit spur);
    int          nb        = 0;
    int          cyc       = 0;
    int          first_cyc = -1;
    bit          held      = 1'b0;
    bit          rdy;
    logic [32:0] saved     = '0;
    if (spur) begin
      bus.QAMDataValid = 1'b1;
      bus.QAMDataRe    = 16'hDEAD;
      bus.QAMDataIm    = 16'hDEAD;
    end
    while (nb < stop_at && cyc < 20000) begin
      bus.Start = spur && (cyc < 8);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.IfftDataReady = rdy;
      if (held)
        chk("stall_stable", 64'({bus.IfftDataValid, bus.IfftDataLast, bus.IfftData}), 64'({1'b1, saved}));
      held = 1'b0;
      if (bus.IfftDataValid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (rdy) begin
          chk("beat_data", 64'(bus.IfftData), 64'(sym(kind, (nb % 64) * 64 + nb / 64)));
          chk("beat_last", 64'(bus.IfftDataLast), 64'((nb % 64) == 63));
          nb++;
        end else begin
          held  = 1'b1;
          saved = {bus.IfftDataLast, bus.IfftData};
        end
      end
      step();
      cyc++;
    end
    bus.Start        = 1'b0;
    bus.QAMDataValid = 1'b0;
    chk("first_valid_latency", 64'(first_cyc >= 0 && first_cyc <= 2), 64'(1));
    chk("beat_count", 64'(nb), 64'(stop_at));
  endtask

  task automatic post_frame_checks();
    int extra = 0;
    chk("valid_after_frame", 64'(bus.IfftDataValid), 64'(0));
    repeat (10) begin
      step();
      if (bus.IfftDataValid) extra++;
    end
    chk("no_extra_beats", 64'(extra), 64'(0));
    chk("cfg_quiet_after_feed", 64'(bus.IfftCfgValid), 64'(0));
    chk("busy_in_drain", 64'(bus.Busy), 64'(1));
  endtask

  task automatic drain_frames();
    chk("tx_idle_before_drain", 64'(bus.OTFSTxValid), 64'(0));
    for (int f = 0; f < 64; f++) begin
      for (int k = 0; k < 64; k++) begin
        bus.IfftOutValid = 1'b1;
        bus.IfftOutData  = {24'hFFFFC0, 24'h000040};
        bus.IfftOutLast  = (k == 63);
        step();
        chk("tx_valid", 64'(bus.OTFSTxValid), 64'(1));
        chk("tx_re", 64'(bus.OTFSTxRe), 64'(ExpTxRe));
        chk("tx_im", 64'(bus.OTFSTxIm), 64'(ExpTxIm));
        chk("done_early", 64'(bus.Done), 64'(0));
      end
    end
    bus.IfftOutValid = 1'b0;
    bus.IfftOutLast  = 1'b0;
    step();
    chk("done_pulse", 64'(bus.Done), 64'(1));
    chk("busy_fall", 64'(bus.Busy), 64'(0));
    chk("tx_valid_fall", 64'(bus.OTFSTxValid), 64'(0));
    step();
    chk("done_one_cycle", 64'(bus.Done), 64'(0));
    chk("busy_idle", 64'(bus.Busy), 64'(0));
  endtask

  initial begin
    Srst              = 1'b1;
    bus.Start         = 1'b0;
    bus.QAMDataValid  = 1'b0;
    bus.QAMDataRe     = '0;
    bus.QAMDataIm     = '0;
    bus.IfftCfgReady  = 1'b0;
    bus.IfftDataReady = 1'b0;
    bus.IfftOutValid  = 1'b0;
    bus.IfftOutData   = '0;
    bus.IfftOutLast   = 1'b0;
    repeat (3) step();
    chk("rst_cfg_valid", 64'(bus.IfftCfgValid), 64'(0));
    chk("rst_cfg_data", 64'(bus.IfftCfgData), 64'(0));
    chk("rst_data_valid", 64'(bus.IfftDataValid), 64'(0));
    chk("rst_data", 64'(bus.IfftData), 64'(0));
    chk("rst_last", 64'(bus.IfftDataLast), 64'(0));
    chk("rst_tx_valid", 64'(bus.OTFSTxValid), 64'(0));
    chk("rst_tx_re", 64'(bus.OTFSTxRe), 64'(0));
    chk("rst_tx_im", 64'(bus.OTFSTxIm), 64'(0));
    chk("rst_busy", 64'(bus.Busy), 64'(0));
    chk("rst_done", 64'(bus.Done), 64'(0));
    Srst = 1'b0;

    // IFFT output while idle must not reach the TX port
    bus.IfftOutValid = 1'b1;
    bus.IfftOutLast  = 1'b1;
    bus.IfftOutData  = {24'h000002, 24'h000040};
    repeat (3) begin
      step();
      chk("tx_valid_in_idle", 64'(bus.OTFSTxValid), 64'(0));
    end
    bus.IfftOutValid = 1'b0;
    bus.IfftOutLast  = 1'b0;

    // Frame 1: ramp data, full throughput, spurious Start/QAM, drain to Done
    start_cfg(5);
    load_frame(0, 1'b1, 1'b0);
    feed_frame(0, 1'b0, 4096, 1'b1);
    post_frame_checks();
    drain_frames();

    // Frame 2: random backpressure, then reset out of DRAIN
    start_cfg(0);
    load_frame(1, 1'b0, 1'b1);
    feed_frame(1, 1'b1, 4096, 1'b0);
    post_frame_checks();
    Srst = 1'b1;
    step();
    Srst = 1'b0;
    chk("busy_after_drain_reset", 64'(bus.Busy), 64'(0));

    // Frame 3: reset after 1000 beats of FEED
    start_cfg(2);
    load_frame(0, 1'b0, 1'b0);
    feed_frame(0, 1'b0, 1000, 1'b0);
    Srst = 1'b1;
    step();
    chk("midfeed_rst_valid", 64'(bus.IfftDataValid), 64'(0));
    chk("midfeed_rst_busy", 64'(bus.Busy), 64'(0));
    chk("midfeed_rst_data", 64'(bus.IfftData), 64'(0));
    chk("midfeed_rst_cfg", 64'(bus.IfftCfgValid), 64'(0));
    Srst = 1'b0;
    step();
    chk("midfeed_idle_valid", 64'(bus.IfftDataValid), 64'(0));
    chk("midfeed_idle_busy", 64'(bus.Busy), 64'(0));

    // Frame 4: fresh load after the reset; first beat must be the new symbol 0
    start_cfg(1);
    load_frame(2, 1'b0, 1'b0);
    feed_frame(2, 1'b0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
